// File: rtl/vga_scan_gen.sv
// Raster timing generator: free-running 10-bit column/line counters with fully
// registered sync, visible-area, picture-window and tick outputs.
module vga_scan_gen #(
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIC_X0     = 192,
  parameter int PIC_Y0     = 112,
  parameter int SCALE_LOG2 = 4
) (
  input  logic       vgaclk,
  input  logic       reset,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       in_pic,
  output logic [3:0] pixelH,
  output logic [3:0] pixelV,
  output logic       line_tick,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int PIC_W   = 16 << SCALE_LOG2;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
      $error("vga_scan_gen: H_TOTAL or V_TOTAL does not fit the 10-bit counters");
    end
    if (PIC_X0 + PIC_W > H_VIS || PIC_Y0 + PIC_W > V_VIS) begin : g_window_check
      $error("vga_scan_gen: picture window extends outside the visible area");
    end
  endgenerate

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] HS_FIRST = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_LAST  = 11'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [10:0] H_VIS_W  = 11'(H_VIS);
  localparam logic [10:0] V_VIS_W  = 11'(V_VIS);
  localparam logic [9:0]  PX0      = 10'(PIC_X0);
  localparam logic [9:0]  PY0      = 10'(PIC_Y0);

  logic [9:0]  h_next, v_next;
  logic [10:0] h_ext, v_ext;
  logic [9:0]  cell_x, cell_y;
  logic        in_pic_next;
  logic        hsync_next, vsync_next, video_on_next;

  // All decodes use the position the counters move to, so every registered
  // output describes the same (hcount, vcount) in a given cycle.
  always_comb begin
    h_next = (hcount == H_LAST) ? 10'd0 : hcount + 10'd1;
    v_next = vcount;
    if (hcount == H_LAST) begin
      v_next = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    end
    h_ext = {1'b0, h_next};
    v_ext = {1'b0, v_next};

    hsync_next    = !((h_ext >= HS_FIRST) && (h_ext <= HS_LAST));
    vsync_next    = !((v_ext >= VS_FIRST) && (v_ext <= VS_LAST));
    video_on_next = (h_ext < H_VIS_W) && (v_ext < V_VIS_W);

    // The window holds exactly 16 cells per axis, so a cell index above 15
    // (or a wrapped negative difference) means outside the window.
    cell_x      = (h_next - PX0) >> SCALE_LOG2;
    cell_y      = (v_next - PY0) >> SCALE_LOG2;
    in_pic_next = (h_next >= PX0) && (cell_x[9:4] == 6'd0) &&
                  (v_next >= PY0) && (cell_y[9:4] == 6'd0);
  end

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      hcount     <= H_LAST;
      vcount     <= V_LAST;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      video_on   <= 1'b0;
      in_pic     <= 1'b0;
      pixelH     <= 4'd0;
      pixelV     <= 4'd0;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      hcount     <= h_next;
      vcount     <= v_next;
      hsync      <= hsync_next;
      vsync      <= vsync_next;
      video_on   <= video_on_next;
      in_pic     <= in_pic_next;
      pixelH     <= in_pic_next ? cell_x[3:0] : 4'd0;
      pixelV     <= in_pic_next ? cell_y[3:0] : 4'd0;
      line_tick  <= (h_next == 10'd0);
      frame_tick <= (h_next == 10'd0) && (v_next == 10'd0);
    end
  end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen: a default-timing instance for line-level
// checks plus two reduced-geometry instances for frame and picture mapping.
module tb_vga_scan_gen;

  logic vgaclk = 1'b0;
  always #20 vgaclk = ~vgaclk;

  logic reset, reset_v, reset_s;

  logic [9:0] hcount, vcount;
  logic       hsync, vsync, video_on, in_pic, line_tick, frame_tick;
  logic [3:0] pixelH, pixelV;

  logic [9:0] hcount_v, vcount_v;
  logic       hsync_v, vsync_v, video_on_v, in_pic_v, line_tick_v, frame_tick_v;
  logic [3:0] pixelH_v, pixelV_v;

  logic [9:0] hcount_s, vcount_s;
  logic       hsync_s, vsync_s, video_on_s, in_pic_s, line_tick_s, frame_tick_s;
  logic [3:0] pixelH_s, pixelV_s;

  vga_scan_gen dut (
    .vgaclk(vgaclk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .in_pic(in_pic),
    .pixelH(pixelH), .pixelV(pixelV), .line_tick(line_tick), .frame_tick(frame_tick)
  );

  // 80x57 raster, 32x32 window at (8,4), 2x2 pixels per cell.
  vga_scan_gen #(
    .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(48), .V_FP(3), .V_SYNC(2), .V_BP(4),
    .PIC_X0(8), .PIC_Y0(4), .SCALE_LOG2(1)
  ) dut_v (
    .vgaclk(vgaclk), .reset(reset_v), .hcount(hcount_v), .vcount(vcount_v),
    .hsync(hsync_v), .vsync(vsync_v), .video_on(video_on_v), .in_pic(in_pic_v),
    .pixelH(pixelH_v), .pixelV(pixelV_v), .line_tick(line_tick_v), .frame_tick(frame_tick_v)
  );

  // 200x152 raster, 128x128 window at the origin, 8x8 pixels per cell.
  vga_scan_gen #(
    .H_VIS(160), .H_FP(8), .H_SYNC(16), .H_BP(16),
    .V_VIS(144), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .PIC_X0(0), .PIC_Y0(0), .SCALE_LOG2(3)
  ) dut_s (
    .vgaclk(vgaclk), .reset(reset_s), .hcount(hcount_s), .vcount(vcount_s),
    .hsync(hsync_s), .vsync(vsync_s), .video_on(video_on_s), .in_pic(in_pic_s),
    .pixelH(pixelH_s), .pixelV(pixelV_s), .line_tick(line_tick_s), .frame_tick(frame_tick_s)
  );

  int total = 0;
  int bad   = 0;

  int pos_err, hs_cnt, hs_first, hs_last, vo_fall, lt_cnt;
  int eh, ev, vs_cnt, vs_off, vo_cnt, vo_off, pic_cnt, lt_cnt_v, ft_cnt_v;

  task automatic tick();
    @(posedge vgaclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic pic(input string tag, input logic i, input logic [3:0] ph, input logic [3:0] pv,
                     input logic ei, input logic [3:0] eph, input logic [3:0] epv);
    chk({tag, "_in"}, i, ei);
    chk({tag, "_ph"}, ph, eph);
    chk({tag, "_pv"}, pv, epv);
  endtask

  initial begin
    reset = 1'b1; reset_v = 1'b1; reset_s = 1'b1;

    // ---- default instance: reset values, held every cycle ----
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_hcount", hcount, 799);
      chk("rst_vcount", vcount, 524);
    end
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_video_on", video_on, 0);
    pic("rst", in_pic, pixelH, pixelV, 0, 0, 0);
    chk("rst_line_tick", line_tick, 0);
    chk("rst_frame_tick", frame_tick, 0);

    reset = 1'b0;
    tick();
    chk("rel_hcount", hcount, 0);
    chk("rel_vcount", vcount, 0);
    chk("rel_frame_tick", frame_tick, 1);
    chk("rel_line_tick", line_tick, 1);
    chk("rel_video_on", video_on, 1);
    chk("rel_hsync", hsync, 1);
    chk("rel_vsync", vsync, 1);
    chk("rel_in_pic", in_pic, 0);

    // ---- one full default line ----
    pos_err = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; vo_fall = -1; lt_cnt = 0;
    for (int c = 0; c < 800; c++) begin
      if (c != 0) tick();
      if (hcount !== 10'(c) || vcount !== 10'd0) pos_err++;
      if (hsync === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = c;
        hs_last = c;
      end
      if (video_on === 1'b0 && vo_fall < 0) vo_fall = c;
      if (line_tick === 1'b1) lt_cnt++;
    end
    chk("line_pos", pos_err, 0);
    chk("line_hsync_len", hs_cnt, 96);
    chk("line_hsync_first", hs_first, 656);
    chk("line_hsync_last", hs_last, 751);
    chk("line_video_fall", vo_fall, 640);
    chk("line_tick_count", lt_cnt, 1);
    tick();
    chk("wrap_hcount", hcount, 0);
    chk("wrap_vcount", vcount, 1);
    chk("wrap_line_tick", line_tick, 1);
    chk("wrap_frame_tick", frame_tick, 0);

    // ---- default instance: reset mid-line at (300,1) ----
    repeat (300) tick();
    chk("mid_hcount", hcount, 300);
    chk("mid_video_on", video_on, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_hcount", hcount, 799);
    chk("mid_rst_vcount", vcount, 524);
    chk("mid_rst_video_on", video_on, 0);
    chk("mid_rst_line_tick", line_tick, 0);
    reset = 1'b0;
    tick();
    chk("mid_rel_hcount", hcount, 0);
    chk("mid_rel_vcount", vcount, 0);
    chk("mid_rel_frame_tick", frame_tick, 1);

    // ---- reduced instance: one whole frame (80x57 = 4560 cycles) ----
    tick();
    reset_v = 1'b0;
    tick();
    chk("v_rel_hcount", hcount_v, 0);
    chk("v_rel_vcount", vcount_v, 0);
    chk("v_rel_frame_tick", frame_tick_v, 1);
    eh = 0; ev = 0; pos_err = 0; vs_cnt = 0; vs_off = 0; vo_cnt = 0; vo_off = 0;
    pic_cnt = 0; lt_cnt_v = 0; ft_cnt_v = 0;
    for (int c = 0; c < 4560; c++) begin
      if (c != 0) tick();
      if (hcount_v !== 10'(eh) || vcount_v !== 10'(ev)) pos_err++;
      if (vsync_v === 1'b0) begin
        vs_cnt++;
        if (ev != 51 && ev != 52) vs_off++;
      end
      if (video_on_v === 1'b1) begin
        vo_cnt++;
        if (ev >= 48 || eh >= 64) vo_off++;
      end
      if (in_pic_v === 1'b1) pic_cnt++;
      if (line_tick_v === 1'b1) lt_cnt_v++;
      if (frame_tick_v === 1'b1) ft_cnt_v++;
      if (eh == 8  && ev == 4)  pic("v_8_4",   in_pic_v, pixelH_v, pixelV_v, 1, 0, 0);
      if (eh == 9  && ev == 5)  pic("v_9_5",   in_pic_v, pixelH_v, pixelV_v, 1, 0, 0);
      if (eh == 10 && ev == 6)  pic("v_10_6",  in_pic_v, pixelH_v, pixelV_v, 1, 1, 1);
      if (eh == 39 && ev == 35) pic("v_39_35", in_pic_v, pixelH_v, pixelV_v, 1, 15, 15);
      if (eh == 40 && ev == 20) pic("v_40_20", in_pic_v, pixelH_v, pixelV_v, 0, 0, 0);
      if (eh == 20 && ev == 36) pic("v_20_36", in_pic_v, pixelH_v, pixelV_v, 0, 0, 0);
      if (eh == 7  && ev == 4)  pic("v_7_4",   in_pic_v, pixelH_v, pixelV_v, 0, 0, 0);
      eh++;
      if (eh == 80) begin
        eh = 0;
        ev++;
      end
    end
    chk("v_frame_pos", pos_err, 0);
    chk("v_vsync_cycles", vs_cnt, 160);
    chk("v_vsync_off_lines", vs_off, 0);
    chk("v_video_cycles", vo_cnt, 3072);
    chk("v_video_off_area", vo_off, 0);
    chk("v_pic_cycles", pic_cnt, 1024);
    chk("v_line_ticks", lt_cnt_v, 57);
    chk("v_frame_ticks", ft_cnt_v, 1);
    tick();
    chk("v_next_frame_hcount", hcount_v, 0);
    chk("v_next_frame_vcount", vcount_v, 0);
    chk("v_next_frame_tick", frame_tick_v, 1);

    // ---- reduced instance: reset mid-frame at (30,25) ----
    repeat (25 * 80 + 30) tick();
    chk("v_mid_hcount", hcount_v, 30);
    chk("v_mid_vcount", vcount_v, 25);
    pic("v_30_25", in_pic_v, pixelH_v, pixelV_v, 1, 11, 10);
    reset_v = 1'b1;
    tick();
    chk("v_mid_rst_hcount", hcount_v, 79);
    chk("v_mid_rst_vcount", vcount_v, 56);
    pic("v_mid_rst", in_pic_v, pixelH_v, pixelV_v, 0, 0, 0);
    chk("v_mid_rst_video_on", video_on_v, 0);
    chk("v_mid_rst_frame_tick", frame_tick_v, 0);
    reset_v = 1'b0;
    tick();
    chk("v_mid_rel_hcount", hcount_v, 0);
    chk("v_mid_rel_vcount", vcount_v, 0);
    chk("v_mid_rel_frame_tick", frame_tick_v, 1);

    // ---- SCALE_LOG2=3 instance with window at the origin ----
    reset_s = 1'b0;
    tick();
    chk("s_rel_hcount", hcount_s, 0);
    pic("s_0_0", in_pic_s, pixelH_s, pixelV_s, 1, 0, 0);
    repeat (128) tick();
    chk("s_128_0_hcount", hcount_s, 128);
    pic("s_128_0", in_pic_s, pixelH_s, pixelV_s, 0, 0, 0);
    repeat (127 * 200 + 127 - 128) tick();
    chk("s_127_127_hcount", hcount_s, 127);
    chk("s_127_127_vcount", vcount_s, 127);
    pic("s_127_127", in_pic_s, pixelH_s, pixelV_s, 1, 15, 15);
    tick();
    pic("s_128_127", in_pic_s, pixelH_s, pixelV_s, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
